ctrl_bubble_stage: RTL and testbench

//  Parametrised ID/EX control-word pipeline register with hazard bubble insertion, replacing the combinational CU-output nop mux.

---
 rtl/ctrl_bubble_stage_pkg.sv | 27 ++
 rtl/ctrl_bubble_stage_if.sv | 33 +++
 rtl/ctrl_bubble_stage_bubble_counter.sv | 38 +++
 rtl/ctrl_bubble_stage.sv | 124 ++++++++++++
 tb/tb_ctrl_bubble_stage.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_bubble_stage_pkg.sv
// Shared definitions for the ID/EX control-word bubble stage.
// Holds default widths, the NOP word, the control-word field layout and the stage state encoding.
package ctrl_bubble_stage_pkg;

  localparam int          CW_W_DEF     = 12;
  localparam logic [11:0] NOP_WORD_DEF = 12'h000;
  localparam int          LEN_W_DEF    = 3;
  localparam int          CNT_W_DEF    = 16;

  // Field layout of the default 12-bit control word, MSB first.
  typedef struct packed {
    logic       shift;
    logic [3:0] alu;
    logic [1:0] size;
    logic       enable;
    logic       rw;
    logic       load;
    logic       s;
    logic       rf;
  } ctrl_word_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } stage_state_e;

endpackage

// File: rtl/ctrl_bubble_stage_if.sv
// Bundle between the control unit / hazard logic and the ID/EX control register.
// The master side drives ID content and hazard controls; the slave side is the stage itself.
interface ctrl_bubble_stage_if
  import ctrl_bubble_stage_pkg::*;
#(
  parameter int CW_W  = CW_W_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  logic [CW_W-1:0]  cw_i;
  logic             valid_i;
  logic             hazard_i;
  logic [LEN_W-1:0] hazard_len_i;
  logic             hold_i;
  logic             flush_i;
  logic [CW_W-1:0]  cw_o;
  logic             valid_o;
  logic             stall_o;
  logic [CNT_W-1:0] bubble_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output cw_i, valid_i, hazard_i, hazard_len_i, hold_i, flush_i,
    input  cw_o, valid_o, stall_o, bubble_cnt_o, flush_cnt_o
  );

  modport slave (
    input  cw_i, valid_i, hazard_i, hazard_len_i, hold_i, flush_i,
    output cw_o, valid_o, stall_o, bubble_cnt_o, flush_cnt_o
  );

endinterface

// File: rtl/ctrl_bubble_stage_bubble_counter.sv
// Loadable down-counter tracking how many bubbles are still owed.
// last is high when the current bubble is the final one of the request.
module bubble_counter #(
  parameter int LEN_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [LEN_W-1:0] load_val,
  input  logic             dec,
  input  logic             clear,
  output logic             last
);

  logic [LEN_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (dec) begin
      count_d = count_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last = (count_q == LEN_W'(1));

endmodule

// File: rtl/ctrl_bubble_stage.sv
// ID/EX control-word register that injects NOP bubbles on hazards and raises the upstream stall.
// Optional statistics counters are built only when CTRL_STAGE_STATS_EN is defined.
module ctrl_bubble_stage
  import ctrl_bubble_stage_pkg::*;
#(
  parameter int              CW_W     = CW_W_DEF,
  parameter logic [CW_W-1:0] NOP_WORD = CW_W'(NOP_WORD_DEF),
  parameter int              LEN_W    = LEN_W_DEF,
  parameter int              CNT_W    = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  ctrl_bubble_stage_if.slave   bus
);

  stage_state_e     state_q, state_d;
  logic [CW_W-1:0]  cw_q, cw_d;
  logic             valid_q, valid_d;
  logic             stall;
  logic             cnt_load, cnt_dec, cnt_clear, cnt_last;
  logic [LEN_W-1:0] cnt_load_val;

  bubble_counter #(.LEN_W(LEN_W)) u_bubble_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .clear    (cnt_clear),
    .last     (cnt_last)
  );

  // Priority: flush > hold > pending bubbles > new hazard > pass-through.
  always_comb begin
    state_d      = state_q;
    cw_d         = cw_q;
    valid_d      = valid_q;
    stall        = 1'b0;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_clear    = 1'b0;
    cnt_load_val = bus.hazard_len_i - LEN_W'(1);
    if (bus.flush_i) begin
      cw_d      = NOP_WORD;
      valid_d   = 1'b0;
      state_d   = ST_RUN;
      cnt_clear = 1'b1;
    end else if (bus.hold_i) begin
      stall = 1'b1;
    end else if (state_q == ST_BUBBLE) begin
      cw_d    = NOP_WORD;
      valid_d = 1'b0;
      stall   = 1'b1;
      cnt_dec = 1'b1;
      if (cnt_last) begin
        state_d = ST_RUN;
      end
    end else if (bus.hazard_i && bus.valid_i) begin
      cw_d    = NOP_WORD;
      valid_d = 1'b0;
      stall   = 1'b1;
      if (bus.hazard_len_i > LEN_W'(1)) begin
        state_d  = ST_BUBBLE;
        cnt_load = 1'b1;
      end
    end else begin
      cw_d    = bus.cw_i;
      valid_d = bus.valid_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      cw_q    <= NOP_WORD;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cw_q    <= cw_d;
      valid_q <= valid_d;
    end
  end

  assign bus.cw_o    = cw_q;
  assign bus.valid_o = valid_q;
  assign bus.stall_o = stall && !reset;

`ifdef CTRL_STAGE_STATS_EN
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             nop_ins;

  // Outside hold, a stall always means a hazard NOP is being loaded this edge.
  assign nop_ins = stall && !bus.hold_i;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (nop_ins && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
    if (bus.flush_i && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bus.bubble_cnt_o = bubble_cnt_q;
  assign bus.flush_cnt_o  = flush_cnt_q;
`else
  assign bus.bubble_cnt_o = '0;
  assign bus.flush_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_ctrl_bubble_stage.sv
// Self-checking bench for ctrl_bubble_stage: directed vector table, random run against a
// bubble-count model, and a narrow-counter instance for saturation.
module tb_ctrl_bubble_stage;
  import ctrl_bubble_stage_pkg::*;

  localparam int CW_W  = 12;
  localparam int LEN_W = 3;
  localparam int CNT_W = 16;
  localparam int SAT_W = 2;
`ifdef CTRL_STAGE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    bit              rst;
    logic [CW_W-1:0] cw;
    bit              valid;
    bit              hazard;
    logic [LEN_W-1:0] len;
    bit              hold;
    bit              flush;
  } stim_t;

  typedef struct {
    stim_t           s;
    bit              e_stall;
    logic [CW_W-1:0] e_cw;
    bit              e_valid;
    int              e_bcnt;
    int              e_fcnt;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic sat_reset;
  always #5 clk = ~clk;

  ctrl_bubble_stage_if #(.CW_W(CW_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();
  ctrl_bubble_stage_if #(.CW_W(CW_W), .LEN_W(LEN_W), .CNT_W(SAT_W)) sbus ();

  ctrl_bubble_stage #(.CW_W(CW_W), .NOP_WORD(12'h000), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  ctrl_bubble_stage #(.CW_W(CW_W), .NOP_WORD(12'h000), .LEN_W(LEN_W), .CNT_W(SAT_W)) sdut (
    .clk   (clk),
    .reset (sat_reset),
    .bus   (sbus)
  );

  int passed = 0;
  int total  = 0;

  // Reference model: outputs plus the number of bubbles still owed.
  logic [CW_W-1:0] m_cw;
  bit              m_valid;
  int              m_left;
  int              m_bcnt;
  int              m_fcnt;
  localparam int   CNT_MAX = (1 << CNT_W) - 1;

  vec_t vecs[29];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic applyStimulus(input stim_t s);
    reset            = s.rst;
    bus.cw_i         = s.cw;
    bus.valid_i      = s.valid;
    bus.hazard_i     = s.hazard;
    bus.hazard_len_i = s.len;
    bus.hold_i       = s.hold;
    bus.flush_i      = s.flush;
  endtask

  function automatic bit modelStall(input stim_t s);
    if (s.rst || s.flush) return 1'b0;
    if (s.hold) return 1'b1;
    if (m_left > 0) return 1'b1;
    return s.hazard && s.valid;
  endfunction

  task automatic modelEdge(input stim_t s);
    int l;
    if (s.rst) begin
      m_cw = '0; m_valid = 0; m_left = 0; m_bcnt = 0; m_fcnt = 0;
    end else if (s.flush) begin
      m_cw = '0; m_valid = 0; m_left = 0;
      if (m_fcnt < CNT_MAX) m_fcnt++;
    end else if (s.hold) begin
      // frozen
    end else if (m_left > 0) begin
      m_cw = '0; m_valid = 0; m_left--;
      if (m_bcnt < CNT_MAX) m_bcnt++;
    end else if (s.hazard && s.valid) begin
      l = (int'(s.len) == 0) ? 1 : int'(s.len);
      m_cw = '0; m_valid = 0; m_left = l - 1;
      if (m_bcnt < CNT_MAX) m_bcnt++;
    end else begin
      m_cw = s.cw; m_valid = s.valid;
    end
  endtask

  // One clock: drive after the edge, sample stall mid-cycle, sample registers just after the next edge.
  task automatic runCycle(input stim_t s, output bit stall_seen, output bit stall_exp);
    applyStimulus(s);
    stall_exp = modelStall(s);
    @(negedge clk);
    stall_seen = bus.stall_o;
    @(posedge clk);
    modelEdge(s);
    #1;
  endtask

  function automatic stim_t mk(input bit rst, input logic [CW_W-1:0] cw, input bit valid,
                               input bit hazard, input logic [LEN_W-1:0] len,
                               input bit hold, input bit flush);
    stim_t s;
    s.rst = rst; s.cw = cw; s.valid = valid; s.hazard = hazard;
    s.len = len; s.hold = hold; s.flush = flush;
    return s;
  endfunction

  task automatic setVec(input int i, input stim_t s, input bit e_stall, input logic [CW_W-1:0] e_cw,
                        input bit e_valid, input int e_bcnt, input int e_fcnt);
    vecs[i].s = s; vecs[i].e_stall = e_stall; vecs[i].e_cw = e_cw;
    vecs[i].e_valid = e_valid; vecs[i].e_bcnt = e_bcnt; vecs[i].e_fcnt = e_fcnt;
  endtask

  initial begin
    bit    st_seen, st_exp;
    stim_t s;

    //           rst cw      v  hz len  hold flush    stall cw      v  bcnt fcnt
    setVec( 0, mk(1, 12'h000, 0, 0, 3'd0, 0, 0), 0, 12'h000, 0,  0, 0);
    setVec( 1, mk(0, 12'hA5C, 1, 0, 3'd0, 0, 0), 0, 12'hA5C, 1,  0, 0);
    setVec( 2, mk(0, 12'h111, 1, 1, 3'd0, 0, 0), 1, 12'h000, 0,  1, 0);
    setVec( 3, mk(0, 12'h222, 1, 0, 3'd0, 0, 0), 0, 12'h222, 1,  1, 0);
    setVec( 4, mk(0, 12'h3F1, 1, 1, 3'd3, 0, 0), 1, 12'h000, 0,  2, 0);
    setVec( 5, mk(0, 12'h3F1, 1, 0, 3'd0, 0, 0), 1, 12'h000, 0,  3, 0);
    setVec( 6, mk(0, 12'h3F1, 1, 0, 3'd0, 0, 0), 1, 12'h000, 0,  4, 0);
    setVec( 7, mk(0, 12'h3F1, 1, 0, 3'd0, 0, 0), 0, 12'h3F1, 1,  4, 0);
    setVec( 8, mk(0, 12'h155, 1, 1, 3'd3, 0, 0), 1, 12'h000, 0,  5, 0);
    setVec( 9, mk(0, 12'h155, 1, 0, 3'd0, 1, 0), 1, 12'h000, 0,  5, 0);
    setVec(10, mk(0, 12'h155, 1, 0, 3'd0, 1, 0), 1, 12'h000, 0,  5, 0);
    setVec(11, mk(0, 12'h155, 1, 0, 3'd0, 0, 0), 1, 12'h000, 0,  6, 0);
    setVec(12, mk(0, 12'h155, 1, 0, 3'd0, 0, 0), 1, 12'h000, 0,  7, 0);
    setVec(13, mk(0, 12'h155, 1, 0, 3'd0, 0, 0), 0, 12'h155, 1,  7, 0);
    setVec(14, mk(0, 12'h0AA, 1, 0, 3'd0, 0, 0), 0, 12'h0AA, 1,  7, 0);
    setVec(15, mk(0, 12'h0BB, 1, 0, 3'd0, 1, 0), 1, 12'h0AA, 1,  7, 0);
    setVec(16, mk(0, 12'h0CC, 1, 1, 3'd3, 0, 0), 1, 12'h000, 0,  8, 0);
    setVec(17, mk(0, 12'h0CC, 1, 0, 3'd0, 1, 1), 0, 12'h000, 0,  8, 1);
    setVec(18, mk(0, 12'h0CC, 1, 0, 3'd0, 0, 0), 0, 12'h0CC, 1,  8, 1);
    setVec(19, mk(0, 12'h0DD, 0, 1, 3'd5, 0, 0), 0, 12'h0DD, 0,  8, 1);
    setVec(20, mk(0, 12'h0EE, 1, 1, 3'd2, 0, 0), 1, 12'h000, 0,  9, 1);
    setVec(21, mk(0, 12'h0EE, 1, 1, 3'd2, 0, 0), 1, 12'h000, 0, 10, 1);
    setVec(22, mk(0, 12'h0EE, 1, 1, 3'd2, 0, 0), 1, 12'h000, 0, 11, 1);
    setVec(23, mk(0, 12'h0EE, 1, 0, 3'd0, 0, 0), 1, 12'h000, 0, 12, 1);
    setVec(24, mk(0, 12'h0EE, 1, 0, 3'd0, 0, 0), 0, 12'h0EE, 1, 12, 1);
    setVec(25, mk(0, 12'h0FF, 1, 1, 3'd4, 0, 0), 1, 12'h000, 0, 13, 1);
    setVec(26, mk(1, 12'h0FF, 1, 0, 3'd0, 0, 0), 0, 12'h000, 0,  0, 0);
    setVec(27, mk(0, 12'h0FF, 1, 0, 3'd0, 0, 0), 0, 12'h0FF, 1,  0, 0);
    setVec(28, mk(0, 12'h123, 1, 0, 3'd0, 1, 1), 0, 12'h000, 0,  0, 1);

    sat_reset = 1'b1;
    sbus.cw_i = '0; sbus.valid_i = 0; sbus.hazard_i = 0; sbus.hazard_len_i = '0;
    sbus.hold_i = 0; sbus.flush_i = 0;
    s = mk(1, 12'h000, 0, 0, 3'd0, 0, 0);
    applyStimulus(s);
    @(posedge clk);
    modelEdge(s);
    #1;

    $display("[TB] directed vector table");
    for (int i = 0; i < 29; i++) begin
      runCycle(vecs[i].s, st_seen, st_exp);
      checkOutput($sformatf("vec%0d_stall", i), 32'(st_seen), 32'(vecs[i].e_stall));
      checkOutput($sformatf("vec%0d_cw", i), 32'(bus.cw_o), 32'(vecs[i].e_cw));
      checkOutput($sformatf("vec%0d_valid", i), 32'(bus.valid_o), 32'(vecs[i].e_valid));
      checkOutput($sformatf("vec%0d_bcnt", i), 32'(bus.bubble_cnt_o), STATS ? 32'(vecs[i].e_bcnt) : 32'd0);
      checkOutput($sformatf("vec%0d_fcnt", i), 32'(bus.flush_cnt_o), STATS ? 32'(vecs[i].e_fcnt) : 32'd0);
    end

    $display("[TB] randomized run against model");
    for (int i = 0; i < 400; i++) begin
      s.rst    = ($urandom_range(63) == 0);
      s.cw     = CW_W'($urandom);
      s.valid  = ($urandom_range(3) != 0);
      s.hazard = ($urandom_range(3) == 0);
      s.len    = LEN_W'($urandom);
      s.hold   = ($urandom_range(7) == 0);
      s.flush  = ($urandom_range(15) == 0);
      runCycle(s, st_seen, st_exp);
      checkOutput($sformatf("rand%0d_stall", i), 32'(st_seen), 32'(st_exp));
      checkOutput($sformatf("rand%0d_cw", i), 32'(bus.cw_o), 32'(m_cw));
      checkOutput($sformatf("rand%0d_valid", i), 32'(bus.valid_o), 32'(m_valid));
      checkOutput($sformatf("rand%0d_bcnt", i), 32'(bus.bubble_cnt_o), STATS ? 32'(m_bcnt) : 32'd0);
      checkOutput($sformatf("rand%0d_fcnt", i), 32'(bus.flush_cnt_o), STATS ? 32'(m_fcnt) : 32'd0);
    end

    $display("[TB] counter saturation on narrow instance");
    sat_reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("sat_reset_bcnt", 32'(sbus.bubble_cnt_o), 32'd0);
    sat_reset = 1'b0;
    sbus.cw_i = 12'h456; sbus.valid_i = 1; sbus.hazard_i = 1; sbus.hazard_len_i = '0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i == 0) checkOutput("sat_bcnt_first", 32'(sbus.bubble_cnt_o), STATS ? 32'd1 : 32'd0);
    end
    checkOutput("sat_bcnt_five", 32'(sbus.bubble_cnt_o), STATS ? 32'd3 : 32'd0);
    sbus.hazard_i = 0; sbus.flush_i = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    checkOutput("sat_fcnt_four", 32'(sbus.flush_cnt_o), STATS ? 32'd3 : 32'd0);
    checkOutput("sat_bcnt_hold", 32'(sbus.bubble_cnt_o), STATS ? 32'd3 : 32'd0);
    sbus.flush_i = 0; sat_reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("sat_clr_bcnt", 32'(sbus.bubble_cnt_o), 32'd0);
    checkOutput("sat_clr_fcnt", 32'(sbus.flush_cnt_o), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
